// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings for the MEM-stage access controller: load/store funct3 codes,
// FSM state codes and lane-enable / store-replication helpers.
package mem_access_ctrl_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] F3_SB = 2'b00;
  localparam logic [1:0] F3_SH = 2'b01;
  localparam logic [1:0] F3_SW = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACCESS   = 2'd1,
    ST_COMPLETE = 2'd2
  } state_t;

  // Access size lives in funct3[1:0] for both loads and stores; codes 10/11 are words.
  function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] a);
    case (size)
      F3_SB:   return 4'b0001 << a;
      F3_SH:   return 4'b0011 << {a[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      F3_SB:   return {4{wd[7:0]}};
      F3_SH:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_load_align_ext.sv
// Load lane selection plus sign/zero extension of the returned memory word.
module load_align_ext
  import mem_access_ctrl_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] read_data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_lane = rdata[{addr_lo, 3'b000} +: 8];
  assign half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    case (funct3)
      F3_LB:   read_data = {{24{byte_lane[7]}}, byte_lane};
      F3_LH:   read_data = {{16{half_lane[15]}}, half_lane};
      F3_LBU:  read_data = {24'd0, byte_lane};
      F3_LHU:  read_data = {16'd0, half_lane};
      default: read_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store controller: byte-enabled memory handshake with pipeline stall,
// timeout abort and optional misalignment trap (define MISALIGN_TRAP_EN).
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  mem_read,
  input  logic [2:0]  mem_write,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        busywait,
  output logic        bus_error,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_byteen,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_busywait
);

  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

  state_t      state_reg, state_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] wdata_reg, wdata_next;
  logic [31:0] rdata_reg, rdata_next;
  logic [3:0]  byteen_reg, byteen_next;
  logic [2:0]  f3_reg, f3_next;
  logic [1:0]  lo_reg, lo_next;
  logic        store_reg, store_next;
  logic        err_reg, err_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic [7:0]  cnt_inc;
  logic [31:0] ext_data;
  logic        req;
  logic        req_store;
  logic [2:0]  req_f3;
  logic        misaligned;

  // A store wins when both enables are raised; the load is silently dropped.
  assign req_store = mem_write[2];
  assign req       = mem_read[3] | mem_write[2];
  assign req_f3    = req_store ? {1'b0, mem_write[1:0]} : mem_read[2:0];
  assign cnt_inc   = cnt_reg + 8'd1;

`ifdef MISALIGN_TRAP_EN
  assign misaligned = ((req_f3[1:0] == F3_SH) && address[0]) ||
                      (req_f3[1] && (address[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  load_align_ext u_align (
    .rdata     (dmem_rdata),
    .addr_lo   (lo_reg),
    .funct3    (f3_reg),
    .read_data (ext_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      rdata_reg  <= '0;
      byteen_reg <= '0;
      f3_reg     <= '0;
      lo_reg     <= '0;
      store_reg  <= 1'b0;
      err_reg    <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      addr_reg   <= addr_next;
      wdata_reg  <= wdata_next;
      rdata_reg  <= rdata_next;
      byteen_reg <= byteen_next;
      f3_reg     <= f3_next;
      lo_reg     <= lo_next;
      store_reg  <= store_next;
      err_reg    <= err_next;
      cnt_reg    <= cnt_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    addr_next   = addr_reg;
    wdata_next  = wdata_reg;
    rdata_next  = rdata_reg;
    byteen_next = byteen_reg;
    f3_next     = f3_reg;
    lo_next     = lo_reg;
    store_next  = store_reg;
    err_next    = err_reg;
    cnt_next    = cnt_reg;
    busywait    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (req) begin
          busywait    = 1'b1;
          addr_next   = {address[31:2], 2'b00};
          lo_next     = address[1:0];
          byteen_next = lane_enables(req_f3[1:0], address[1:0]);
          wdata_next  = replicate(req_f3[1:0], write_data);
          f3_next     = req_f3;
          store_next  = req_store;
          cnt_next    = '0;
          rdata_next  = '0;
          err_next    = misaligned;
          state_next  = misaligned ? ST_COMPLETE : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        busywait = 1'b1;
        if (!dmem_busywait) begin
          rdata_next = store_reg ? 32'd0 : ext_data;
          state_next = ST_COMPLETE;
        end else if (cnt_inc == TIMEOUT_LIM) begin
          rdata_next = '0;
          err_next   = 1'b1;
          state_next = ST_COMPLETE;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      ST_COMPLETE: state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  assign dmem_read   = (state_reg == ST_ACCESS) && !store_reg;
  assign dmem_write  = (state_reg == ST_ACCESS) && store_reg;
  assign dmem_addr   = addr_reg;
  assign dmem_byteen = byteen_reg;
  assign dmem_wdata  = wdata_reg;
  assign read_data   = rdata_reg;
  assign bus_error   = (state_reg == ST_COMPLETE) && err_reg;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: table of load/store vectors against a latency-
// programmable memory model, plus reset sequences.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  mem_read;
  logic [2:0]  mem_write;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        busywait;
  logic        bus_error;
  logic        dmem_read;
  logic        dmem_write;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_byteen;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_busywait;

  int checks = 0;
  int errors = 0;

  // Memory stays busy for the first mem_lat strobe cycles, ready on the next one.
  int unsigned mem_lat = 0;
  int unsigned busy_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) busy_cnt <= (dmem_read | dmem_write) ? busy_cnt + 1 : 0;
  assign dmem_busywait = (dmem_read | dmem_write) && (busy_cnt < mem_lat);

  mem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .address       (address),
    .write_data    (write_data),
    .read_data     (read_data),
    .busywait      (busywait),
    .bus_error     (bus_error),
    .dmem_read     (dmem_read),
    .dmem_write    (dmem_write),
    .dmem_addr     (dmem_addr),
    .dmem_byteen   (dmem_byteen),
    .dmem_wdata    (dmem_wdata),
    .dmem_rdata    (dmem_rdata),
    .dmem_busywait (dmem_busywait)
  );

  typedef struct {
    string       name;
    logic [3:0]  rd;
    logic [2:0]  wr;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rdata;
    int          lat;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic        e_read;
    logic        e_write;
    logic [31:0] e_rdata;
    logic        e_err;
    int          e_stall;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];

  function automatic vec_t mk(input string name, input logic [3:0] rd, input logic [2:0] wr,
                              input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdata,
                              input int lat, input logic [31:0] e_addr, input logic [3:0] e_be,
                              input logic [31:0] e_wdata, input logic e_read, input logic e_write,
                              input logic [31:0] e_rdata, input logic e_err, input int e_stall);
    vec_t t;
    t.name = name; t.rd = rd; t.wr = wr; t.a = a; t.wd = wd; t.rdata = rdata; t.lat = lat;
    t.e_addr = e_addr; t.e_be = e_be; t.e_wdata = e_wdata; t.e_read = e_read;
    t.e_write = e_write; t.e_rdata = e_rdata; t.e_err = e_err; t.e_stall = e_stall;
    return t;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t t);
    int          stall;
    int          strobes;
    logic        seen;
    logic        done;
    logic        c_rd, c_wr;
    logic [31:0] c_addr, c_wd;
    logic [3:0]  c_be;
    @(negedge clk);
    mem_read   = t.rd;
    mem_write  = t.wr;
    address    = t.a;
    write_data = t.wd;
    dmem_rdata = t.rdata;
    mem_lat    = t.lat;
    stall = 0; strobes = 0; seen = 1'b0; done = 1'b0;
    c_rd = 1'b0; c_wr = 1'b0; c_addr = '0; c_wd = '0; c_be = '0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (!busywait) begin
        done = 1'b1;
        break;
      end
      stall++;
      if (dmem_read | dmem_write) begin
        strobes++;
        if (!seen) begin
          seen = 1'b1; c_rd = dmem_read; c_wr = dmem_write;
          c_addr = dmem_addr; c_be = dmem_byteen; c_wd = dmem_wdata;
        end
      end
      @(negedge clk);
    end
    check({t.name, " completed"}, 32'(done), 32'd1);
    check({t.name, " stall"}, 32'(stall), 32'(t.e_stall));
    check({t.name, " strobe_cycles"}, 32'(strobes),
          (t.e_read | t.e_write) ? 32'(t.e_stall - 1) : 32'd0);
    check({t.name, " dmem_read"}, 32'(c_rd), 32'(t.e_read));
    check({t.name, " dmem_write"}, 32'(c_wr), 32'(t.e_write));
    if (t.e_read | t.e_write) begin
      check({t.name, " dmem_addr"}, c_addr, t.e_addr);
      check({t.name, " byteen"}, 32'(c_be), 32'(t.e_be));
      check({t.name, " wdata"}, c_wd, t.e_wdata);
    end
    check({t.name, " read_data"}, read_data, t.e_rdata);
    check({t.name, " bus_error"}, 32'(bus_error), 32'(t.e_err));
    $display("txn %s: stall=%0d read_data=0x%08h bus_error=%0b", t.name, stall, read_data, bus_error);
    mem_read  = '0;
    mem_write = '0;
    @(negedge clk);
    #1;
    check({t.name, " release busywait"}, 32'(busywait), 32'd0);
    check({t.name, " release bus_error"}, 32'(bus_error), 32'd0);
  endtask

  initial begin
    //        name        rd       wr       a             wd            rdata         lat  addr          be       wdata         r  w  read_data     err stall
    vecs[0]  = mk("lw",      4'b1010, 3'b000, 32'h100, 32'h0,        32'hDEADBEEF, 2,  32'h100, 4'b1111, 32'h0,        1, 0, 32'hDEADBEEF, 0, 4);
    vecs[1]  = mk("lb",      4'b1000, 3'b000, 32'h103, 32'h0,        32'h80123456, 0,  32'h100, 4'b1000, 32'h0,        1, 0, 32'hFFFFFF80, 0, 2);
    vecs[2]  = mk("lbu",     4'b1100, 3'b000, 32'h103, 32'h0,        32'h80123456, 0,  32'h100, 4'b1000, 32'h0,        1, 0, 32'h00000080, 0, 2);
    vecs[3]  = mk("sh",      4'b0000, 3'b101, 32'h102, 32'h0000ABCD, 32'hFFFFFFFF, 1,  32'h100, 4'b1100, 32'hABCDABCD, 0, 1, 32'h0,        0, 3);
    vecs[4]  = mk("lh",      4'b1001, 3'b000, 32'h102, 32'h0,        32'h80123456, 1,  32'h100, 4'b1100, 32'h0,        1, 0, 32'hFFFF8012, 0, 3);
    vecs[5]  = mk("lhu",     4'b1101, 3'b000, 32'h100, 32'h0,        32'h1234F00D, 0,  32'h100, 4'b0011, 32'h0,        1, 0, 32'h0000F00D, 0, 2);
    vecs[6]  = mk("sb",      4'b0000, 3'b100, 32'h201, 32'h123456A5, 32'h0,        2,  32'h200, 4'b0010, 32'hA5A5A5A5, 0, 1, 32'h0,        0, 4);
    vecs[7]  = mk("sw",      4'b0000, 3'b110, 32'h300, 32'hCAFEF00D, 32'h0,        0,  32'h300, 4'b1111, 32'hCAFEF00D, 0, 1, 32'h0,        0, 2);
    vecs[8]  = mk("both",    4'b1010, 3'b100, 32'h400, 32'h00000011, 32'h12345678, 0,  32'h400, 4'b0001, 32'h11111111, 0, 1, 32'h0,        0, 2);
    vecs[9]  = mk("ld_f011", 4'b1011, 3'b000, 32'h104, 32'h0,        32'h89ABCDEF, 0,  32'h104, 4'b1111, 32'h0,        1, 0, 32'h89ABCDEF, 0, 2);
    vecs[10] = mk("st_f11",  4'b0000, 3'b111, 32'h108, 32'h01020304, 32'h0,        0,  32'h108, 4'b1111, 32'h01020304, 0, 1, 32'h0,        0, 2);
    vecs[11] = mk("lb_pos",  4'b1000, 3'b000, 32'h101, 32'h0,        32'h00007F00, 0,  32'h100, 4'b0010, 32'h0,        1, 0, 32'h0000007F, 0, 2);
    // Memory never ready: four busy ACCESS cycles then abort.
    vecs[12] = mk("timeout", 4'b1010, 3'b000, 32'h500, 32'h0,        32'hA5A5A5A5, 255, 32'h500, 4'b1111, 32'h0,       1, 0, 32'h0,        1, 5);
`ifdef MISALIGN_TRAP_EN
    vecs[13] = mk("lw_mis",  4'b1010, 3'b000, 32'h101, 32'h0,        32'h01234567, 0,  32'h0,   4'b0000, 32'h0,        0, 0, 32'h0,        1, 1);
`else
    vecs[13] = mk("lw_mis",  4'b1010, 3'b000, 32'h101, 32'h0,        32'h01234567, 0,  32'h100, 4'b1111, 32'h0,        1, 0, 32'h01234567, 0, 2);
`endif

    reset = 1'b1; mem_read = '0; mem_write = '0; address = '0; write_data = '0; dmem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst busywait", 32'(busywait), 32'd0);
    check("rst dmem_read", 32'(dmem_read), 32'd0);
    check("rst dmem_write", 32'(dmem_write), 32'd0);
    check("rst bus_error", 32'(bus_error), 32'd0);
    check("rst read_data", read_data, 32'd0);
    check("rst dmem_addr", dmem_addr, 32'd0);
    check("rst byteen", 32'(dmem_byteen), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) run_vec(vecs[i]);

    // Reset while the memory is still busy drops the transaction.
    @(negedge clk);
    mem_read = 4'b1010; address = 32'h600; mem_lat = 255;
    #1;
    check("rstmid request busywait", 32'(busywait), 32'd1);
    @(negedge clk);
    #1;
    check("rstmid in access dmem_read", 32'(dmem_read), 32'd1);
    reset = 1'b1;
    mem_read = '0;
    @(negedge clk);
    #1;
    check("rstmid dmem_read", 32'(dmem_read), 32'd0);
    check("rstmid dmem_write", 32'(dmem_write), 32'd0);
    check("rstmid busywait", 32'(busywait), 32'd0);
    check("rstmid bus_error", 32'(bus_error), 32'd0);
    $display("txn reset_mid_access: dmem_read=%0b busywait=%0b", dmem_read, busywait);
    reset = 1'b0;
    @(negedge clk);
    #1;
    check("rstmid idle dmem_read", 32'(dmem_read), 32'd0);
    check("rstmid idle bus_error", 32'(bus_error), 32'd0);
    run_vec(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
